tdm_mux_scan: RTL and testbench

//  Parametrised, registered N-to-1 word multiplexer, successor to the 4x1 bit mux.

---
 rtl/tdm_mux_pkg.sv | 27 ++
 rtl/tdm_mux_scan_rr_next_ch.sv | 43 ++++
 rtl/tdm_mux_scan.sv | 181 ++++++++++++++++++
 tb/tb_tdm_mux_scan.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the TDM word multiplexer.
//   state_t : stream FSM states
//   mode_t  : channel-selection mode encoding
//   ch_idx_w: ceil(log2(n)), minimum 1, for index widths
package tdm_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  // Bits needed to index n items; never less than 1.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = 32'(i + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/tdm_mux_scan_rr_next_ch.sv
// Rotate-priority finder: first enabled channel at or after a start index,
// wrapping past NUM_CH-1.
//   ch_mask   : channel enables, bit i = channel i
//   start     : index where the search begins
//   next_ch_c : first enabled index found
//   found_c   : any channel enabled
//   wrapped_c : the found index lies below start (search wrapped)
module rr_next_ch
  import tdm_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [SEL_W-1:0]  start,
  output logic [SEL_W-1:0]  next_ch_c,
  output logic              found_c,
  output logic              wrapped_c
);

  // Wrapped candidates first, then in-order candidates override; descending
  // loops leave the lowest qualifying index in each pass.
  always_comb begin
    next_ch_c = '0;
    found_c   = 1'b0;
    wrapped_c = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i] && (SEL_W'(i) < start)) begin
        next_ch_c = SEL_W'(i);
        found_c   = 1'b1;
        wrapped_c = 1'b1;
      end
    end
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i] && (SEL_W'(i) >= start)) begin
        next_ch_c = SEL_W'(i);
        found_c   = 1'b1;
        wrapped_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_mux_scan.sv
// Registered NUM_CH-to-1 word multiplexer with valid/ready output stream.
// Manual mode loads the channel given by sel; scan mode walks the enabled
// channels round-robin, staying DWELL accepted beats on each.
//   clk, reset_n          : clock, async active-low reset
//   en, mode, sel, ch_mask: control (mode 0 = manual, 1 = scan)
//   din                   : packed channel words, channel i at [i*DATA_W +: DATA_W]
//   dout, out_valid       : registered output word and its valid
//   out_ready             : consumer accepts dout
//   cur_ch                : channel dout came from
//   wrap, err             : one-cycle pulses (scan wrap-around, bad manual sel)
module tdm_mux_scan
  import tdm_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DWELL  = 1,
  parameter int unsigned SEL_W  = ch_idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic [DATA_W-1:0]        dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         cur_ch,
  output logic                     wrap,
  output logic                     err
);

  localparam int unsigned CNT_W = (DWELL > 1) ? ch_idx_w(DWELL) : 1;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   cur_ch_q, cur_ch_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic               beat;
  logic               dwell_done;
  logic               sel_bad;
  logic [SEL_W-1:0]   adv_start;
  logic [SEL_W-1:0]   rr_start;
  logic [SEL_W-1:0]   rr_next;
  logic               rr_found;
  logic               rr_wrapped;
  logic [SEL_W-1:0]   load_ch;
  logic               ch_bad;
  logic [DATA_W-1:0]  word;

  assign beat       = valid_q & out_ready;
  assign dwell_done = (dwell_q == CNT_W'(DWELL - 1));
  assign sel_bad    = ({1'b0, sel} >= (SEL_W + 1)'(NUM_CH));
  assign adv_start  = (cur_ch_q == SEL_W'(NUM_CH - 1)) ? '0 : cur_ch_q + SEL_W'(1);
  // From IDLE the search resumes at the scan pointer; in a stream it starts after cur_ch.
  assign rr_start   = (state_q == IDLE) ? ptr_q : adv_start;

  rr_next_ch #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr (
    .ch_mask   (ch_mask),
    .start     (rr_start),
    .next_ch_c (rr_next),
    .found_c   (rr_found),
    .wrapped_c (rr_wrapped)
  );

  // Channel the next load would use, whether or not a load happens.
  always_comb begin
    load_ch = cur_ch_q;
    ch_bad  = 1'b0;
    if (mode == MODE_MANUAL) begin
      if (sel_bad) begin
        load_ch = '0;
        ch_bad  = 1'b1;
      end else begin
        load_ch = sel;
      end
    end else if ((state_q == IDLE) || dwell_done) begin
      load_ch = rr_next;
    end
  end

  // Word select; an out-of-range manual sel yields zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (load_ch == SEL_W'(i)) word = din[i*DATA_W +: DATA_W];
    end
    if (ch_bad) word = '0;
  end

  // Stream FSM: next state, loads, dwell and pulse generation.
  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    cur_ch_d = cur_ch_q;
    wrap_d   = 1'b0;
    err_d    = 1'b0;
    dwell_d  = dwell_q;
    ptr_d    = ptr_q;

    unique case (state_q)
      IDLE: begin
        dwell_d = '0;
        if (en && ((mode == MODE_MANUAL) || rr_found)) begin
          state_d  = STREAM;
          valid_d  = 1'b1;
          dout_d   = word;
          cur_ch_d = load_ch;
          err_d    = ch_bad;
          if (mode == MODE_SCAN) ptr_d = load_ch;
        end
      end

      STREAM: begin
        if (!en || (beat && (mode == MODE_SCAN) && !rr_found)) begin
          state_d = IDLE;
          valid_d = 1'b0;
          dwell_d = '0;
        end else if (beat) begin
          dout_d   = word;
          cur_ch_d = load_ch;
          err_d    = ch_bad;
          if (mode == MODE_MANUAL) begin
            dwell_d = '0;
          end else if (dwell_done) begin
            dwell_d = '0;
            ptr_d   = load_ch;
            // New index <= old index; the last channel always wraps.
            wrap_d  = rr_wrapped | (cur_ch_q == SEL_W'(NUM_CH - 1));
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      cur_ch_q <= '0;
      wrap_q   <= 1'b0;
      err_q    <= 1'b0;
      dwell_q  <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      cur_ch_q <= cur_ch_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      dwell_q  <= dwell_d;
      ptr_q    <= ptr_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = valid_q;
  assign cur_ch    = cur_ch_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tdm_mux_scan.sv
// Directed bench for tdm_mux_scan: a 4-channel DWELL=2 instance and a
// 3-channel DWELL=1 instance sharing clock and reset.
module tb_tdm_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;

  logic       en, mode, out_ready;
  logic [1:0] sel;
  logic [3:0] ch_mask;
  logic [31:0] din;
  logic [7:0] dout;
  logic       out_valid;
  logic [1:0] cur_ch;
  logic       wrap, err;

  logic       b_en, b_mode, b_ready;
  logic [1:0] b_sel;
  logic [2:0] b_mask;
  logic [23:0] b_din;
  logic [7:0] b_dout;
  logic       b_valid;
  logic [1:0] b_cur;
  logic       b_wrap, b_err;

  int total = 0;
  int bad   = 0;

  tdm_mux_scan #(.NUM_CH(4), .DATA_W(8), .DWELL(2)) u4 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .sel(sel),
    .ch_mask(ch_mask), .din(din), .dout(dout), .out_valid(out_valid),
    .out_ready(out_ready), .cur_ch(cur_ch), .wrap(wrap), .err(err)
  );

  tdm_mux_scan #(.NUM_CH(3), .DATA_W(8), .DWELL(1)) u3 (
    .clk(clk), .reset_n(reset_n), .en(b_en), .mode(b_mode), .sel(b_sel),
    .ch_mask(b_mask), .din(b_din), .dout(b_dout), .out_valid(b_valid),
    .out_ready(b_ready), .cur_ch(b_cur), .wrap(b_wrap), .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_man [4];
  logic [1:0] exp_ch  [8];
  logic       exp_wr  [8];
  logic [7:0] exp_dat [8];

  initial begin
    exp_man = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_ch  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
    exp_wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_dat = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h44, 8'h44, 8'h11, 8'h11};

    reset_n = 1'b0;
    en = 1'b0; mode = 1'b0; sel = 2'd0; ch_mask = 4'b0000;
    din = 32'h44332211; out_ready = 1'b1;
    b_en = 1'b0; b_mode = 1'b0; b_sel = 2'd0; b_mask = 3'b000;
    b_din = 24'hCCBBAA; b_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_cur", 32'(cur_ch), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_b_valid", 32'(b_valid), 32'h0);
    step();
    step();
    reset_n = 1'b1;

    // NUM_CH=3 manual, out-of-range sel
    b_en = 1'b1; b_sel = 2'd3;
    step();
    chk("m3_bad_dout", 32'(b_dout), 32'h0);
    chk("m3_bad_cur", 32'(b_cur), 32'h0);
    chk("m3_bad_err", 32'(b_err), 32'h1);
    chk("m3_bad_valid", 32'(b_valid), 32'h1);
    b_sel = 2'd1;
    step();
    chk("m3_sel1_dout", 32'(b_dout), 32'hBB);
    chk("m3_sel1_cur", 32'(b_cur), 32'h1);
    chk("m3_sel1_err", 32'(b_err), 32'h0);
    b_sel = 2'd3;
    step();
    chk("m3_bad2_dout", 32'(b_dout), 32'h0);
    chk("m3_bad2_err", 32'(b_err), 32'h1);
    chk("m3_bad2_valid", 32'(b_valid), 32'h1);
    b_sel = 2'd2;
    step();
    chk("m3_sel2_dout", 32'(b_dout), 32'hCC);
    chk("m3_sel2_cur", 32'(b_cur), 32'h2);
    chk("m3_sel2_err", 32'(b_err), 32'h0);
    b_en = 1'b0;
    step();
    chk("m3_off_valid", 32'(b_valid), 32'h0);
    chk("m3_off_dout", 32'(b_dout), 32'hCC);

    // Manual sweep, one word per clock
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      chk($sformatf("man_dout%0d", i), 32'(dout), 32'(exp_man[i]));
      chk($sformatf("man_cur%0d", i), 32'(cur_ch), 32'(i));
      chk($sformatf("man_valid%0d", i), 32'(out_valid), 32'h1);
    end

    // Stall for three clocks, then release
    sel = 2'd1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_dout%0d", i), 32'(dout), 32'h44);
      chk($sformatf("stall_cur%0d", i), 32'(cur_ch), 32'h3);
      chk($sformatf("stall_valid%0d", i), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_word", 32'(dout), 32'h44);
    step();
    chk("after_rel_dout", 32'(dout), 32'h22);
    chk("after_rel_cur", 32'(cur_ch), 32'h1);

    // en=0 together with a beat: beat taken, no reload, IDLE
    en = 1'b0;
    step();
    chk("en_off_valid", 32'(out_valid), 32'h0);
    chk("en_off_dout", 32'(dout), 32'h22);

    // Scan, DWELL=2, mask 1011
    mode = 1'b1; ch_mask = 4'b1011; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("scan_cur%0d", i), 32'(cur_ch), 32'(exp_ch[i]));
      chk($sformatf("scan_wrap%0d", i), 32'(wrap), 32'(exp_wr[i]));
      chk($sformatf("scan_dout%0d", i), 32'(dout), 32'(exp_dat[i]));
      chk($sformatf("scan_valid%0d", i), 32'(out_valid), 32'h1);
    end

    // Asynchronous reset between edges mid-stream
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_cur", 32'(cur_ch), 32'h0);

    // Scan with empty mask stays idle
    ch_mask = 4'b0000;
    step();
    reset_n = 1'b1;
    step();
    chk("empty_valid0", 32'(out_valid), 32'h0);
    step();
    chk("empty_valid1", 32'(out_valid), 32'h0);

    // Single enabled channel: wraps on every advance
    ch_mask = 4'b0100;
    step();
    chk("one_cur0", 32'(cur_ch), 32'h2);
    chk("one_dout0", 32'(dout), 32'h33);
    chk("one_wrap0", 32'(wrap), 32'h0);
    chk("one_valid0", 32'(out_valid), 32'h1);
    step();
    chk("one_wrap1", 32'(wrap), 32'h0);
    step();
    chk("one_cur2", 32'(cur_ch), 32'h2);
    chk("one_wrap2", 32'(wrap), 32'h1);
    step();
    chk("one_wrap3", 32'(wrap), 32'h0);
    step();
    chk("one_wrap4", 32'(wrap), 32'h1);

    // Reset while wrap is high, then restart from channel 0
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst2_wrap", 32'(wrap), 32'h0);
    chk("arst2_valid", 32'(out_valid), 32'h0);
    chk("arst2_dout", 32'(dout), 32'h0);
    ch_mask = 4'b1111;
    #2;
    reset_n = 1'b1;
    #1;
    chk("rel_valid", 32'(out_valid), 32'h0);
    step();
    chk("restart_cur", 32'(cur_ch), 32'h0);
    chk("restart_dout", 32'(dout), 32'h11);
    chk("restart_valid", 32'(out_valid), 32'h1);
    step();
    chk("restart_dwell_cur", 32'(cur_ch), 32'h0);
    step();
    chk("restart_adv_cur", 32'(cur_ch), 32'h1);
    chk("restart_adv_dout", 32'(dout), 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
